bus_cmd_initiator: RTL and testbench

//  Bus initiator (master) for the 16-bit register bus served by the Bus_* responder blocks.

---
 rtl/bus_cmd_initiator_if.sv | 39 +++
 rtl/bus_cmd_initiator.sv | 131 +++++++++++++
 tb/tb_bus_cmd_initiator.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bus_cmd_initiator_if.sv
// rtl/bus_cmd_initiator_if.sv - command, bus and response signals of the register-bus initiator
interface bus_cmd_initiator_if;
  // command channel
  logic        i_Cmd_DV;
  logic        i_Cmd_Wr_Rd_n;
  logic [7:0]  i_Cmd_Addr;
  logic [15:0] i_Cmd_Wr_Data;
  logic        o_Cmd_Ready;
  // register bus
  logic        o_Bus_CS;
  logic        o_Bus_Wr_Rd_n;
  logic [7:0]  o_Bus_Addr8;
  logic [15:0] o_Bus_Wr_Data;
  logic [15:0] i_Bus_Rd_Data;
  logic        i_Bus_Rd_DV;
  // response channel
  logic        o_Rsp_DV;
  logic        o_Rsp_Wr_Rd_n;
  logic [15:0] o_Rsp_Rd_Data;
  logic        o_Rsp_Timeout;

  // initiator view
  modport master (
    input  i_Cmd_DV, i_Cmd_Wr_Rd_n, i_Cmd_Addr, i_Cmd_Wr_Data,
    output o_Cmd_Ready,
    output o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data,
    input  i_Bus_Rd_Data, i_Bus_Rd_DV,
    output o_Rsp_DV, o_Rsp_Wr_Rd_n, o_Rsp_Rd_Data, o_Rsp_Timeout
  );

  // command source / responder view
  modport slave (
    output i_Cmd_DV, i_Cmd_Wr_Rd_n, i_Cmd_Addr, i_Cmd_Wr_Data,
    input  o_Cmd_Ready,
    input  o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data,
    output i_Bus_Rd_Data, i_Bus_Rd_DV,
    input  o_Rsp_DV, o_Rsp_Wr_Rd_n, o_Rsp_Rd_Data, o_Rsp_Timeout
  );
endinterface

// File: rtl/bus_cmd_initiator.sv
// rtl/bus_cmd_initiator.sv - single-outstanding register-bus initiator with read timeout
module bus_cmd_initiator #(
  parameter int unsigned g_TIMEOUT_CYCLES = 15,
  parameter logic [15:0] g_TIMEOUT_DATA   = 16'hDEAD
) (
  input  logic                  i_Bus_Clk,
  input  logic                  i_Bus_Rst_L,
  bus_cmd_initiator_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Counter value on the final WAIT_RD cycle; reaching it ends the wait.
  localparam logic [7:0] LAST_CNT = 8'(g_TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_cs_q, bus_cs_d;
  logic        bus_wr_q, bus_wr_d;
  logic [7:0]  bus_addr_q, bus_addr_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;
  logic        rsp_dv_q, rsp_dv_d;
  logic        rsp_wr_q, rsp_wr_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_to_q, rsp_to_d;

  // Next-state logic; bus registers double as the command latch so they hold after CS drops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_cs_d    = 1'b0;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_dv_d    = 1'b0;
    rsp_wr_d    = rsp_wr_q;
    rsp_data_d  = rsp_data_q;
    rsp_to_d    = rsp_to_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_Cmd_DV) begin
          bus_cs_d    = 1'b1;
          bus_wr_d    = bus.i_Cmd_Wr_Rd_n;
          bus_addr_d  = bus.i_Cmd_Addr;
          bus_wdata_d = bus.i_Cmd_Wr_Data;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus_wr_q) begin
          rsp_dv_d   = 1'b1;
          rsp_wr_d   = 1'b1;
          rsp_data_d = 16'h0000;
          rsp_to_d   = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d   = 8'd0;
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        // Read data takes priority over expiry on the same cycle.
        if (bus.i_Bus_Rd_DV) begin
          rsp_dv_d   = 1'b1;
          rsp_wr_d   = 1'b0;
          rsp_data_d = bus.i_Bus_Rd_Data;
          rsp_to_d   = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == LAST_CNT) begin
          rsp_dv_d   = 1'b1;
          rsp_wr_d   = 1'b0;
          rsp_data_d = g_TIMEOUT_DATA;
          rsp_to_d   = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction with no response.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_cs_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= 8'd0;
      bus_wdata_q <= 16'd0;
      rsp_dv_q    <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_data_q  <= 16'd0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_cs_q    <= bus_cs_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_dv_q    <= rsp_dv_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign bus.o_Cmd_Ready   = (state_q == S_IDLE);
  assign bus.o_Bus_CS      = bus_cs_q;
  assign bus.o_Bus_Wr_Rd_n = bus_wr_q;
  assign bus.o_Bus_Addr8   = bus_addr_q;
  assign bus.o_Bus_Wr_Data = bus_wdata_q;
  assign bus.o_Rsp_DV      = rsp_dv_q;
  assign bus.o_Rsp_Wr_Rd_n = rsp_wr_q;
  assign bus.o_Rsp_Rd_Data = rsp_data_q;
  assign bus.o_Rsp_Timeout = rsp_to_q;

endmodule

// File: tb/tb_bus_cmd_initiator.sv
// tb/tb_bus_cmd_initiator.sv - randomized self-checking bench for bus_cmd_initiator
module tb_bus_cmd_initiator;

  localparam int          T      = 15;
  localparam logic [15:0] TO_DAT = 16'hDEAD;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  bus_cmd_initiator_if bif ();

  bus_cmd_initiator #(
    .g_TIMEOUT_CYCLES (T),
    .g_TIMEOUT_DATA   (TO_DAT)
  ) dut (
    .i_Bus_Clk   (clk),
    .i_Bus_Rst_L (rst_n),
    .bus         (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command from accept to the cycle after its response. Called at a negedge.
  // k: responder asserts Rd_DV k cycles after the CS cycle (values above T never arrive in time).
  // stray: Rd_DV also pulsed during the CS cycle with junk data.
  task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int k, input bit stray, input bit hold);
    int          exp_off;
    logic [15:0] exp_data;
    bit          exp_to;
    int          off;
    int          cs_cnt;
    int          rdy_hi;
    bit          seen;

    // reference: response offset from the accept cycle and its contents
    if (wr) begin
      exp_off = 2;  exp_data = 16'h0000; exp_to = 1'b0;
    end else if (k <= T) begin
      exp_off = 2 + k; exp_data = rdata; exp_to = 1'b0;
    end else begin
      exp_off = 2 + T; exp_data = TO_DAT; exp_to = 1'b1;
    end

    bif.i_Cmd_DV      = 1'b1;
    bif.i_Cmd_Wr_Rd_n = wr;
    bif.i_Cmd_Addr    = addr;
    bif.i_Cmd_Wr_Data = wdata;
    chk("rdy_at_accept", bif.o_Cmd_Ready, 1);

    off = 0; cs_cnt = 0; rdy_hi = 0; seen = 1'b0;
    while (!seen && off < exp_off + 4) begin
      @(negedge clk);
      off++;
      if (off == 1 && !hold) bif.i_Cmd_DV = 1'b0;
      if (bif.o_Bus_CS) cs_cnt++;
      if (bif.o_Cmd_Ready) rdy_hi++;
      if (bif.o_Rsp_DV) seen = 1'b1;
      if (off == 1) begin
        chk("cs_n1", bif.o_Bus_CS, 1);
        chk("bus_wr", bif.o_Bus_Wr_Rd_n, wr);
        chk("bus_addr", bif.o_Bus_Addr8, addr);
        if (wr) chk("bus_wdata", bif.o_Bus_Wr_Data, wdata);
      end
      bif.i_Bus_Rd_DV   = (off == 1 && stray) || (off == 1 + k);
      bif.i_Bus_Rd_Data = (off == 1 + k) ? rdata : 16'($urandom);
    end
    bif.i_Bus_Rd_DV = 1'b0;

    chk("cs_pulses", cs_cnt, 1);
    chk("rsp_latency", off, exp_off);
    chk("rdy_low", rdy_hi, 0);
    chk("rsp_wr", bif.o_Rsp_Wr_Rd_n, wr);
    chk("rsp_data", bif.o_Rsp_Rd_Data, exp_data);
    chk("rsp_timeout", bif.o_Rsp_Timeout, exp_to);

    @(negedge clk);
    chk("rsp_one_cycle", bif.o_Rsp_DV, 0);
    chk("rdy_after", bif.o_Cmd_Ready, 1);
    chk("rsp_hold_data", bif.o_Rsp_Rd_Data, exp_data);
  endtask

  initial begin
    int seen_rsp;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bif.i_Cmd_DV = 1'b0;
    bif.i_Cmd_Wr_Rd_n = 1'b0;
    bif.i_Cmd_Addr = 8'h00;
    bif.i_Cmd_Wr_Data = 16'h0000;
    bif.i_Bus_Rd_Data = 16'h0000;
    bif.i_Bus_Rd_DV = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", bif.o_Bus_CS, 0);
    chk("rst_rsp_dv", bif.o_Rsp_DV, 0);
    chk("rst_timeout", bif.o_Rsp_Timeout, 0);
    chk("rst_addr", bif.o_Bus_Addr8, 0);
    chk("rst_wdata", bif.o_Bus_Wr_Data, 0);
    chk("rst_rdata", bif.o_Rsp_Rd_Data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", bif.o_Cmd_Ready, 1);

    // directed cases
    run_cmd(1'b1, 8'h00, 16'h0001, 16'h0000, 0, 1'b0, 1'b0);       // write
    run_cmd(1'b0, 8'h02, 16'h0000, 16'h0003, 1, 1'b0, 1'b0);       // read, data at N+2
    run_cmd(1'b0, 8'h04, 16'h0000, 16'h0000, T + 5, 1'b0, 1'b0);   // read timeout
    run_cmd(1'b0, 8'h06, 16'h0000, 16'h1234, T, 1'b1, 1'b0);       // data on expiry cycle + stray

    // back-to-back with valid held high
    run_cmd(1'b1, 8'h10, 16'hA5A5, 16'h0000, 0, 1'b0, 1'b1);
    run_cmd(1'b0, 8'h11, 16'h0000, 16'h5A5A, 3, 1'b1, 1'b1);
    run_cmd(1'b1, 8'h12, 16'h3C3C, 16'h0000, 0, 1'b0, 1'b1);
    bif.i_Cmd_DV = 1'b0;

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(1, T + 3)), 1'($urandom), 1'b0);
    end

    // reset during WAIT_RD
    bif.i_Cmd_DV = 1'b1;
    bif.i_Cmd_Wr_Rd_n = 1'b0;
    bif.i_Cmd_Addr = 8'h20;
    @(negedge clk);
    bif.i_Cmd_DV = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", bif.o_Bus_CS, 0);
    chk("abort_rsp_dv", bif.o_Rsp_DV, 0);
    chk("abort_timeout", bif.o_Rsp_Timeout, 0);
    seen_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (bif.o_Rsp_DV) seen_rsp++;
    end
    rst_n = 1'b1;
    repeat (T + 4) begin
      @(negedge clk);
      if (bif.o_Rsp_DV) seen_rsp++;
    end
    chk("abort_no_rsp", seen_rsp, 0);
    chk("abort_rdy", bif.o_Cmd_Ready, 1);
    run_cmd(1'b1, 8'h21, 16'hBEEF, 16'h0000, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
